// File: rtl/vga_source_compositor_if.sv
// Bundles the pixel-source inputs and VGA-side outputs of the source compositor.
// Source k occupies iRGB[k*3*COLOR_W +: 3*COLOR_W], packed {R,G,B}.
interface vga_source_compositor_if #(
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 1,
  parameter int COLOR_W = 4
);
  logic [NUM_SRC*3*COLOR_W-1:0] iRGB;
  logic                         iVGA_VS;
  logic [SEL_W-1:0]             iSel;
  logic [COLOR_W-1:0]           oRed;
  logic [COLOR_W-1:0]           oGreen;
  logic [COLOR_W-1:0]           oBlue;
  logic                         oVGA_VS;
  logic [SEL_W-1:0]             oActive;
  logic                         oBusy;

  modport master (
    output iRGB, iVGA_VS, iSel,
    input  oRed, oGreen, oBlue, oVGA_VS, oActive, oBusy
  );

  modport slave (
    input  iRGB, iVGA_VS, iSel,
    output oRed, oGreen, oBlue, oVGA_VS, oActive, oBusy
  );
endinterface

// File: rtl/vga_source_compositor.sv
// Frame-synchronous N-way VGA source selector with optional black frames on a switch.
// 1-cycle pixel/VS latency; source changes commit on a falling VS edge.
module vga_source_compositor #(
  parameter int                 NUM_SRC      = 2,
  parameter int                 SEL_W        = 1,
  parameter int                 COLOR_W      = 4,
  parameter int                 BLANK_FRAMES = 1,
  parameter int                 RESET_SRC    = 0,
  parameter logic [NUM_SRC-1:0] VS_PASS_MASK = 2'b01
) (
  input logic                    iVGA_CLK,
  input logic                    iRST_n,
  vga_source_compositor_if.slave vif
);

  localparam int                PIX_W     = 3 * COLOR_W;
  localparam int                SEL_N     = 2 ** SEL_W;
  localparam logic [SEL_N-1:0]  VS_MASK   = SEL_N'(VS_PASS_MASK);
  localparam logic [SEL_W:0]    NUM_SRC_V = (SEL_W + 1)'(NUM_SRC);
  localparam logic [SEL_W-1:0]  RESET_SEL = SEL_W'(RESET_SRC);
  localparam logic [3:0]        BLANK_CNT = 4'(BLANK_FRAMES);

  typedef enum logic [1:0] {IDLE, WAIT_VS, BLANK} state_t;

  state_t             state_q, state_d;
  logic [SEL_W-1:0]   active_q, active_d;
  logic [SEL_W-1:0]   pending_q, pending_d;
  logic [3:0]         count_q, count_d;
  logic               vs_d_q, vs_d_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic               vs_out_q, vs_out_d;

  logic               sel_valid;
  logic               frame_edge;
  logic               commit;
  logic [PIX_W-1:0]   pix_sel;

  always_comb begin
    sel_valid  = ({1'b0, vif.iSel} < NUM_SRC_V);
    frame_edge = vs_d_q & ~vif.iVGA_VS;
    state_d    = state_q;
    active_d   = active_q;
    pending_d  = pending_q;
    count_d    = count_q;
    commit     = 1'b0;
    vs_d_d     = vif.iVGA_VS;

    case (state_q)
      IDLE: begin
        // An edge arriving with the request is deliberately not consumed here.
        if (sel_valid && (vif.iSel != active_q)) begin
          pending_d = vif.iSel;
          state_d   = WAIT_VS;
        end
      end
      WAIT_VS: begin
        if (sel_valid) pending_d = vif.iSel;
        if (frame_edge) begin
          if (BLANK_CNT == 4'd0) begin
            commit = 1'b1;
          end else begin
            state_d = BLANK;
            count_d = 4'd1;
          end
        end
      end
      BLANK: begin
        if (sel_valid) pending_d = vif.iSel;
        if (frame_edge) begin
          if (count_q == BLANK_CNT) commit = 1'b1;
          else                      count_d = count_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (commit) begin
      active_d = pending_d;
      state_d  = IDLE;
      count_d  = 4'd0;
    end
  end

  always_comb begin
    pix_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (active_q == SEL_W'(k)) pix_sel = vif.iRGB[k*PIX_W +: PIX_W];
    end
    pix_d    = (state_q == BLANK) ? '0 : pix_sel;
    // VS follows the committed source, so blanking never touches it.
    vs_out_d = vif.iVGA_VS & VS_MASK[active_q];
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q   <= IDLE;
      active_q  <= RESET_SEL;
      pending_q <= RESET_SEL;
      count_q   <= 4'd0;
      vs_d_q    <= 1'b1;
      pix_q     <= '0;
      vs_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      count_q   <= count_d;
      vs_d_q    <= vs_d_d;
      pix_q     <= pix_d;
      vs_out_q  <= vs_out_d;
    end
  end

  assign vif.oRed    = pix_q[2*COLOR_W +: COLOR_W];
  assign vif.oGreen  = pix_q[COLOR_W +: COLOR_W];
  assign vif.oBlue   = pix_q[0 +: COLOR_W];
  assign vif.oVGA_VS = vs_out_q;
  assign vif.oActive = active_q;
  assign vif.oBusy   = (state_q != IDLE);

endmodule

// File: tb/tb_vga_source_compositor.sv
// Bench for vga_source_compositor: two instances (one and zero blank frames) share stimulus
// and are checked against a frame-level reference model plus directed timing checks.
module tb_vga_source_compositor;
  localparam int NS = 4, SW = 3, CW = 4, PW = 12, FRAME = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NS*PW-1:0] rgb;
  logic             vs;
  logic [SW-1:0]    sel;
  int               fcnt;
  bit               rand_all;
  int               n_chk = 0;
  int               n_fail = 0;

  vga_source_compositor_if #(.NUM_SRC(NS), .SEL_W(SW), .COLOR_W(CW)) if_a ();
  vga_source_compositor_if #(.NUM_SRC(NS), .SEL_W(SW), .COLOR_W(CW)) if_b ();

  assign if_a.iRGB = rgb;  assign if_a.iVGA_VS = vs;  assign if_a.iSel = sel;
  assign if_b.iRGB = rgb;  assign if_b.iVGA_VS = vs;  assign if_b.iSel = sel;

  vga_source_compositor #(.NUM_SRC(NS), .SEL_W(SW), .COLOR_W(CW), .BLANK_FRAMES(1),
                          .RESET_SRC(0), .VS_PASS_MASK(4'b0001)) dut_a (
    .iVGA_CLK(clk), .iRST_n(rst_n), .vif(if_a));
  vga_source_compositor #(.NUM_SRC(NS), .SEL_W(SW), .COLOR_W(CW), .BLANK_FRAMES(0),
                          .RESET_SRC(0), .VS_PASS_MASK(4'b1001)) dut_b (
    .iVGA_CLK(clk), .iRST_n(rst_n), .vif(if_b));

  // Reference model: a switch is a target plus a countdown of frame edges still to see.
  typedef struct {
    logic [2:0]  active;
    logic        busy;
    logic [2:0]  target;
    int          left;
    logic        vs_prev;
    logic [11:0] rgb_out;
    logic        vs_out;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.active = 3'd0; m.busy = 1'b0; m.target = 3'd0; m.left = 0;
    m.vs_prev = 1'b1; m.rgb_out = 12'h000; m.vs_out = 1'b0;
    return m;
  endfunction

  function automatic model_t step(model_t m, int bf, logic [3:0] mask,
                                  logic [NS*PW-1:0] rgb_i, logic vs_i, logic [2:0] sel_i);
    model_t n = m;
    bit frame_edge = m.vs_prev && !vs_i;
    bit blanking   = m.busy && (m.left <= bf);
    n.rgb_out = blanking ? 12'h000 : rgb_i[int'(m.active)*PW +: PW];
    n.vs_out  = vs_i & mask[m.active];
    n.vs_prev = vs_i;
    if (!m.busy) begin
      if (sel_i < 3'(NS) && sel_i != m.active) begin
        n.busy = 1'b1; n.target = sel_i; n.left = bf + 1;
      end
    end else begin
      if (sel_i < 3'(NS)) n.target = sel_i;
      if (frame_edge) begin
        n.left = m.left - 1;
        if (n.left == 0) begin
          n.active = n.target; n.busy = 1'b0;
        end
      end
    end
    return n;
  endfunction

  model_t ma, mb;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= step(ma, 1, 4'b0001, rgb, vs, sel);
      mb <= step(mb, 0, 4'b1001, rgb, vs, sel);
    end
  end

  logic [16:0] obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {if_a.oRed, if_a.oGreen, if_a.oBlue, if_a.oVGA_VS, if_a.oActive, if_a.oBusy};
  assign obs_b = {if_b.oRed, if_b.oGreen, if_b.oBlue, if_b.oVGA_VS, if_b.oActive, if_b.oBusy};
  assign exp_a = {ma.rgb_out, ma.vs_out, ma.active, ma.busy};
  assign exp_b = {mb.rgb_out, mb.vs_out, mb.active, mb.busy};

  task automatic drive_next(output bit edge_o);
    logic prev = vs;
    fcnt = (fcnt + 1) % FRAME;
    vs   = (fcnt >= 2);
    rgb[0*PW +: PW] = rand_all ? 12'($urandom) : 12'hABC;
    rgb[1*PW +: PW] = rand_all ? 12'($urandom) : 12'h0F0;
    rgb[2*PW +: PW] = 12'($urandom);
    rgb[3*PW +: PW] = 12'($urandom);
    edge_o = prev && !vs;
  endtask

  task automatic test_reset();
    bit e;
    repeat (3) @(negedge clk);
    n_chk += 2;
    if (obs_a !== 17'h0) begin n_fail++; $display("FAIL reset_a got %h want %h", obs_a, 17'h0); end
    if (obs_b !== 17'h0) begin n_fail++; $display("FAIL reset_b got %h want %h", obs_b, 17'h0); end
    rst_n = 1'b1;
    @(negedge clk);
    n_chk += 2;
    if ({if_a.oRed, if_a.oGreen, if_a.oBlue} !== 12'hABC) begin
      n_fail++; $display("FAIL reset_first_pix got %h want abc", {if_a.oRed, if_a.oGreen, if_a.oBlue});
    end
    if (if_a.oVGA_VS !== 1'b1) begin n_fail++; $display("FAIL reset_vs_follow got %b want 1", if_a.oVGA_VS); end
    drive_next(e);
    repeat (2 * FRAME) begin
      @(negedge clk);
      n_chk += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL reset_run_a got %h want %h", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL reset_run_b got %h want %h", obs_b, exp_b); end
      drive_next(e);
    end
  endtask

  task automatic test_switch_blank();
    bit e;
    int zeros = 0;
    sel = 3'd1;
    @(negedge clk);
    n_chk++;
    if (if_a.oBusy !== 1'b1) begin n_fail++; $display("FAIL switch_busy got %b want 1", if_a.oBusy); end
    drive_next(e);
    repeat (3 * FRAME) begin
      @(negedge clk);
      n_chk += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL switch_a got %h want %h", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL switch_b got %h want %h", obs_b, exp_b); end
      if ({if_a.oRed, if_a.oGreen, if_a.oBlue} == 12'h000) zeros++;
      drive_next(e);
    end
    n_chk += 4;
    if (zeros != FRAME) begin n_fail++; $display("FAIL switch_blank_len got %0d want %0d", zeros, FRAME); end
    if (if_a.oActive !== 3'd1) begin n_fail++; $display("FAIL switch_active got %0d want 1", if_a.oActive); end
    if ({if_a.oRed, if_a.oGreen, if_a.oBlue} !== 12'h0F0) begin
      n_fail++; $display("FAIL switch_pix got %h want 0f0", {if_a.oRed, if_a.oGreen, if_a.oBlue});
    end
    if (if_a.oVGA_VS !== 1'b0) begin n_fail++; $display("FAIL switch_vs_masked got %b want 0", if_a.oVGA_VS); end
  endtask

  task automatic test_no_blank();
    bit e;
    int edge_i = -1;
    logic [11:0] s3_prev = 12'h000;
    sel = 3'd3;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      n_chk += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL noblank_a got %h want %h", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL noblank_b got %h want %h", obs_b, exp_b); end
      if (edge_i >= 0 && i == edge_i + 1) begin
        n_chk += 2;
        if (if_b.oActive !== 3'd3) begin n_fail++; $display("FAIL noblank_active got %0d want 3", if_b.oActive); end
        if ({if_b.oRed, if_b.oGreen, if_b.oBlue} !== 12'h0F0) begin
          n_fail++; $display("FAIL noblank_old_pix got %h want 0f0", {if_b.oRed, if_b.oGreen, if_b.oBlue});
        end
      end
      if (edge_i >= 0 && i == edge_i + 2) begin
        n_chk++;
        if ({if_b.oRed, if_b.oGreen, if_b.oBlue} !== s3_prev) begin
          n_fail++; $display("FAIL noblank_new_pix got %h want %h", {if_b.oRed, if_b.oGreen, if_b.oBlue}, s3_prev);
        end
      end
      drive_next(e);
      s3_prev = rgb[3*PW +: PW];
      if (e && edge_i < 0) edge_i = i;
    end
    repeat (FRAME) begin
      @(negedge clk);
      n_chk += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL noblank_tail_a got %h want %h", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL noblank_tail_b got %h want %h", obs_b, exp_b); end
      drive_next(e);
    end
  endtask

  task automatic test_last_wins();
    bit e;
    int edge_i = -1;
    sel = 3'd1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      n_chk += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL lastwins_a got %h want %h", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL lastwins_b got %h want %h", obs_b, exp_b); end
      drive_next(e);
      if (e && edge_i < 0) edge_i = i;
      if (edge_i >= 0 && i == edge_i + 3) sel = 3'd2;
    end
    n_chk += 2;
    if (if_a.oActive !== 3'd2) begin n_fail++; $display("FAIL lastwins_active_a got %0d want 2", if_a.oActive); end
    if (if_b.oActive !== 3'd2) begin n_fail++; $display("FAIL lastwins_active_b got %0d want 2", if_b.oActive); end
    sel = 3'd5;
    repeat (FRAME + 4) begin
      @(negedge clk);
      n_chk += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL invalid_a got %h want %h", obs_a, exp_a); end
      if (if_a.oBusy !== 1'b0 || if_a.oActive !== 3'd2) begin
        n_fail++; $display("FAIL invalid_idle got busy=%b act=%0d want busy=0 act=2", if_a.oBusy, if_a.oActive);
      end
      drive_next(e);
    end
  endtask

  task automatic test_simultaneous();
    bit e;
    for (int i = 0; i <= FRAME; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL simul_pre_a got %h want %h", obs_a, exp_a); end
      if (fcnt == FRAME - 1) break;
      drive_next(e);
    end
    drive_next(e);
    sel = 3'd0;
    n_chk++;
    if (!e) begin n_fail++; $display("FAIL simul_align got edge=%b want 1", e); end
    repeat (FRAME + 4) begin
      @(negedge clk);
      n_chk += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL simul_a got %h want %h", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL simul_b got %h want %h", obs_b, exp_b); end
      drive_next(e);
    end
    n_chk += 2;
    if (if_a.oBusy !== 1'b1 || if_a.oActive !== 3'd2) begin
      n_fail++; $display("FAIL simul_still_busy got busy=%b act=%0d want busy=1 act=2", if_a.oBusy, if_a.oActive);
    end
    if (if_b.oBusy !== 1'b0 || if_b.oActive !== 3'd0) begin
      n_fail++; $display("FAIL simul_b_commit got busy=%b act=%0d want busy=0 act=0", if_b.oBusy, if_b.oActive);
    end
    repeat (FRAME) begin
      @(negedge clk);
      n_chk++;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL simul_tail_a got %h want %h", obs_a, exp_a); end
      drive_next(e);
    end
    n_chk++;
    if (if_a.oActive !== 3'd0) begin n_fail++; $display("FAIL simul_final got %0d want 0", if_a.oActive); end
  endtask

  task automatic test_reset_blank();
    bit e;
    int edge_i = -1;
    int zeros = 0;
    sel = 3'd1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      n_chk++;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL rstblank_pre_a got %h want %h", obs_a, exp_a); end
      if (edge_i >= 0 && i == edge_i + 4) break;
      drive_next(e);
      if (e && edge_i < 0) edge_i = i;
    end
    n_chk++;
    if ({if_a.oRed, if_a.oGreen, if_a.oBlue} !== 12'h000 || if_a.oBusy !== 1'b1) begin
      n_fail++; $display("FAIL rstblank_in_blank got pix=%h busy=%b want pix=000 busy=1",
                         {if_a.oRed, if_a.oGreen, if_a.oBlue}, if_a.oBusy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_chk += 2;
    if (obs_a !== 17'h0) begin n_fail++; $display("FAIL rstblank_async_a got %h want %h", obs_a, 17'h0); end
    if (obs_b !== 17'h0) begin n_fail++; $display("FAIL rstblank_async_b got %h want %h", obs_b, 17'h0); end
    sel = 3'd0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) begin
      @(negedge clk);
      n_chk += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL rstblank_a got %h want %h", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL rstblank_b got %h want %h", obs_b, exp_b); end
      if ({if_a.oRed, if_a.oGreen, if_a.oBlue} !== 12'hABC) zeros++;
      drive_next(e);
    end
    n_chk++;
    if (zeros != 0) begin n_fail++; $display("FAIL rstblank_no_blank got %0d non-src0 cycles want 0", zeros); end
  endtask

  task automatic test_random();
    bit e;
    rand_all = 1'b1;
    repeat (1500) begin
      @(negedge clk);
      n_chk += 2;
      if (obs_a !== exp_a) begin n_fail++; $display("FAIL random_a got %h want %h", obs_a, exp_a); end
      if (obs_b !== exp_b) begin n_fail++; $display("FAIL random_b got %h want %h", obs_b, exp_b); end
      drive_next(e);
      if ($urandom_range(0, 29) == 0) sel = 3'($urandom_range(0, 7));
    end
  endtask

  initial begin
    rand_all = 1'b0;
    fcnt = 5;
    vs = 1'b1;
    sel = 3'd0;
    rgb = '0;
    rgb[0*PW +: PW] = 12'hABC;
    rgb[1*PW +: PW] = 12'h0F0;
    test_reset();
    test_switch_blank();
    test_no_blank();
    test_last_wins();
    test_simultaneous();
    test_reset_blank();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
